wb_arbiter_n: RTL

Parametrised Wishbone (classic, single-beat) arbiter that merges NUM_MASTERS master channels onto one slave port. It sits between the core's instruction-fetch and data-memory master ports and the shared cache/memory slave, replacing fixed two-port wiring. Arbitration is round-robin or fixed-priority. An optional watchdog returns an error to a master whose transfer the slave never acknowledges.

---
 rtl/lc3b_types.sv | 13 +
 rtl/wb_arbiter_n_picker.sv | 33 +++
 rtl/wb_arbiter_n.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types and Wishbone port defaults for the LC-3b core and its bus blocks.
package lc3b_types;

  localparam int WB_ADDR_WIDTH = 12;
  localparam int WB_DATA_WIDTH = 128;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_n_picker.sv
// Combinational winner selection: first requester at/after start (round-robin)
// or lowest requesting index (fixed priority, mode = 1).
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] start,
  input  logic          mode,
  output logic [GW-1:0] winner,
  output logic          valid
);

  localparam int IW = GW + 1;

  always_comb begin
    logic [IW-1:0] idx;
    logic [GW-1:0] base;
    winner = '0;
    valid  = 1'b0;
    base   = mode ? '0 : start;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, base} + IW'(k);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!valid && req[idx[GW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master single-beat Wishbone arbiter with optional slave-wait watchdog.
// ARB_IDLE | sample requests, register winner ; ARB_BUSY | forward owner to slave
module wb_arbiter_n
  import lc3b_types::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDR_WIDTH    = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 0,
  localparam int SW  = DATA_WIDTH / 8,
  localparam int GW  = idx_width(NUM_MASTERS),
  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_m,
  input  logic [NUM_MASTERS*SW-1:0]         m_sel,
  output logic [DATA_WIDTH-1:0]             m_dat_s,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_m,
  output logic [SW-1:0]                     s_sel,
  input  logic [DATA_WIDTH-1:0]             s_dat_s,
  input  logic                              s_ack,
  output logic [GW-1:0]                     grant
);

  arb_state_t state;
  logic [GW-1:0]         rr_ptr, pick_idx, grant_inc;
  logic                  pick_valid, busy, cyc_g, timeout_hit;
  logic [WCW-1:0]        wait_cnt;
  logic [NUM_MASTERS-1:0] req;
  logic [ADDR_WIDTH-1:0] adr_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_a [NUM_MASTERS];
  logic [SW-1:0]         sel_a [NUM_MASTERS];

  assign req = m_cyc & m_stb;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign adr_a[i] = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[i] = m_dat_m[i*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[i] = m_sel[i*SW +: SW];
  end

  rr_priority_picker #(.N(NUM_MASTERS), .GW(GW)) u_picker (
    .req    (req),
    .start  (rr_ptr),
    .mode   (PRIORITY_MODE != 0),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign busy        = (state == ARB_BUSY);
  assign cyc_g       = busy & m_cyc[grant];
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WCW'(TIMEOUT - 1));
  assign grant_inc   = (grant == GW'(NUM_MASTERS - 1)) ? '0 : grant + GW'(1);
  assign m_dat_s     = s_dat_s;

  // A dropped m_cyc hides the owner from the slave and swallows any late ack.
  always_comb begin
    m_ack   = '0;
    m_err   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_m = '0;
    s_sel   = '0;
    if (cyc_g) begin
      s_cyc        = m_stb[grant];
      s_stb        = m_stb[grant];
      s_we         = m_we[grant];
      s_adr        = adr_a[grant];
      s_dat_m      = dat_a[grant];
      s_sel        = sel_a[grant];
      m_ack[grant] = s_ack;
      m_err[grant] = ~s_ack & timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state    <= ARB_BUSY;
            grant    <= pick_idx;
            wait_cnt <= '0;
          end
        end
        ARB_BUSY: begin
          if (!cyc_g) begin
            state <= ARB_IDLE;
          end else if (s_ack || timeout_hit) begin
            state <= ARB_IDLE;
            if (PRIORITY_MODE == 0) rr_ptr <= grant_inc;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
